// File: rtl/dvi_timing_gen.sv
// Raster timing generator for the pixel clock domain: free-running h/v counters
// with registered sync, data-enable, coordinate and frame/line marker outputs.
module dvi_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             adv;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic             active_h, active_v, hs_reg, vs_reg;

  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             ls_q, ls_d, fs_q, fs_d, vblank_q, vblank_d;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The cycle that enters RUN holds the counters at (0,0); dropping enable
  // clears everything on the very next edge, with no line completion.
  always_comb adv = (state_q == RUN) && enable;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!adv) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    active_h = h_cnt_q < H_ACT_C;
    active_v = v_cnt_q < V_ACT_C;
    hs_reg   = (h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C);
    vs_reg   = (v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C);
  end

  always_comb begin
    hsync_d  = ~HS_POL;
    vsync_d  = ~VS_POL;
    de_d     = 1'b0;
    x_d      = '0;
    y_d      = '0;
    ls_d     = 1'b0;
    fs_d     = 1'b0;
    vblank_d = 1'b1;
    if (adv) begin
      hsync_d  = hs_reg ? HS_POL : ~HS_POL;
      vsync_d  = vs_reg ? VS_POL : ~VS_POL;
      de_d     = active_h && active_v;
      x_d      = de_d ? h_cnt_q : '0;
      y_d      = de_d ? v_cnt_q : '0;
      ls_d     = (h_cnt_q == '0) && active_v;
      fs_d     = (h_cnt_q == '0) && (v_cnt_q == '0);
      vblank_d = ~active_v;
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      de_q     <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      vblank_q <= 1'b1;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      vblank_q <= vblank_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign vblank      = vblank_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: a default SVGA instance and a small-raster instance
// checked every cycle against a run-length based raster model.
module tb_dvi_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en_d = 1'b0;
  logic en_s = 1'b0;

  always #5 clk = ~clk;

  logic        hs_d, vs_d, de_d, ls_d, fs_d, vb_d;
  logic [11:0] x_d, y_d;
  logic        hs_s, vs_s, de_s, ls_s, fs_s, vb_s;
  logic [11:0] x_s, y_s;

  dvi_timing_gen u_dflt (
    .clkin(clk), .reset(rst_n), .enable(en_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .vblank(vb_d)
  );

  dvi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
  ) u_small (
    .clkin(clk), .reset(rst_n), .enable(en_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s), .vblank(vb_s)
  );

  int total = 0;
  int bad = 0;
  // consecutive edges that sampled enable=1 (0 after reset or a disable edge)
  int n_d = 0;
  int n_s = 0;

  // Output after an edge depends only on how long enable has been held:
  // the first edge enters RUN, the second shows pixel 0 of frame 0.
  function automatic logic [29:0] model(input int n, input int ha, input int hfp,
      input int hsw, input int hbp, input int va, input int vfp, input int vsw,
      input int vbp, input bit hp, input bit vp);
    int ht, vt, p, h, v;
    logic act;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (n < 2) return {~hp, ~vp, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1};
    p = (n - 2) % (ht * vt);
    h = p % ht;
    v = p / ht;
    act = (h < ha) && (v < va);
    return {((h >= ha + hfp) && (h < ha + hfp + hsw)) ? hp : ~hp,
            ((v >= va + vfp) && (v < va + vfp + vsw)) ? vp : ~vp,
            act, act ? 12'(h) : 12'd0, act ? 12'(v) : 12'd0,
            (h == 0) && (v < va), (h == 0) && (v == 0), v >= va};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("dflt_vec", {2'b0, hs_d, vs_d, de_d, x_d, y_d, ls_d, fs_d, vb_d},
        {2'b0, model(n_d, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1)});
    chk("small_vec", {2'b0, hs_s, vs_s, de_s, x_s, y_s, ls_s, fs_s, vb_s},
        {2'b0, model(n_s, 8, 2, 3, 1, 4, 1, 2, 1, 1'b0, 1'b0)});
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      n_d = 0;
      n_s = 0;
    end else begin
      n_d = en_d ? n_d + 1 : 0;
      n_s = en_s ? n_s + 1 : 0;
    end
    #1;
    check_all();
  endtask

  logic [23:0] exp_q[$];
  int de_cnt, hs_cnt, hs_first, sde, shs, svs;
  logic [23:0] got;

  initial begin
    // reset held with enable requested: everything idles
    #1 rst_n = 1'b0;
    en_d = 1'b1;
    en_s = 1'b1;
    #1;
    check_all();
    repeat (3) step();
    chk("rst_hsync", 32'(hs_d), 32'd0);
    chk("rst_vblank", 32'(vb_d), 32'd1);

    // release mid-cycle: first edge enters RUN, second shows frame_start
    rst_n = 1'b1;
    step();
    chk("fs_edge1", 32'(fs_d), 32'd0);
    step();
    chk("fs_edge2", 32'(fs_d), 32'd1);
    chk("fs_small_edge2", 32'(fs_s), 32'd1);

    // one full default line and one full small frame, measured from frame_start
    de_cnt = 0; hs_cnt = 0; hs_first = -1; sde = 0; shs = 0; svs = 0;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++) exp_q.push_back({12'(yy), 12'(xx)});
    for (int k = 0; k <= 1056; k++) begin
      if (k > 0) step();
      if (k < 1056) begin
        if (de_d) de_cnt++;
        if (hs_d) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
        end
      end else begin
        chk("ls_period", 32'(ls_d), 32'd1);
      end
      if (k < 112) begin
        if (de_s) begin
          sde++;
          got = {y_s, x_s};
          if (exp_q.size() > 0) chk("small_raster", 32'(got), 32'(exp_q.pop_front()));
          else chk("small_raster_extra", 32'(got), 32'hffffff);
        end
        if (!hs_s) shs++;
        if (!vs_s) svs++;
      end
    end
    chk("de_high_len", 32'(de_cnt), 32'd800);
    chk("hs_high_len", 32'(hs_cnt), 32'd128);
    chk("hs_rise_ofs", 32'(hs_first), 32'd840);
    chk("small_de_cnt", 32'(sde), 32'd32);
    chk("small_hs_low", 32'(shs), 32'd24);
    chk("small_vs_low", 32'(svs), 32'd28);
    chk("small_raster_left", 32'(exp_q.size()), 32'd0);

    // drop the default raster at line 2 pixel 400, re-enable after 10 cycles
    while (n_d - 2 != 2 * 1056 + 400) step();
    en_d = 1'b0;
    step();
    chk("drop_de", 32'(de_d), 32'd0);
    repeat (9) step();
    en_d = 1'b1;
    step();
    step();
    chk("reen_fs", 32'(fs_d), 32'd1);

    // drop the small raster exactly on its frame-wrap edge
    while ((n_s - 2) % 112 != 110) step();
    en_s = 1'b0;
    step();
    chk("wrap_drop_fs", 32'(fs_s), 32'd0);
    en_s = 1'b1;

    // random enable activity on the small raster
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en_s = ~en_s;
      step();
    end
    en_s = 1'b1;
    repeat (20) step();

    // asynchronous reset between edges: outputs idle before any edge
    #2 rst_n = 1'b0;
    #1;
    n_d = 0;
    n_s = 0;
    check_all();
    chk("arst_de", 32'(de_d), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (200) step();
    chk("restart_y", 32'(n_d), 32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Raster timing generator in the pixel clock domain, directly downstream of the DVI clock manager.
- Clocked by pixel_clk1x (40 MHz for SVGA). Produces hsync, vsync, data-enable and pixel coordinates.
- Outputs feed the TMDS encoder/serializer stage and the pixel source.
- Defaults give VESA 800x600@60, H_TOTAL 1056, V_TOTAL 628.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, hsync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CNT_W, 12, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clkin  input  1  pixel clock (pixel_clk1x from the clock manager)
reset  input  1  asynchronous, active-low reset
enable  input  1  run request; tie to PLL/BUFPLL lock qualified in the pixel domain
hsync  output  1  horizontal sync at HS_POL level
vsync  output  1  vertical sync at VS_POL level
de  output  1  data enable: high in the active region
x  output  CNT_W  pixel column; valid when de=1
y  output  CNT_W  pixel row; valid when de=1
line_start  output  1  one-cycle pulse on pixel (0, any active row)
frame_start  output  1  one-cycle pulse on pixel (0,0)
vblank  output  1  high while the line is outside the active rows

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Internal counters:
  - h_cnt counts 0..H_TOTAL-1, increments every clkin while running, and wraps to 0.
  - v_cnt increments when h_cnt wraps. v_cnt wraps 0..V_TOTAL-1.
  - When h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, both counters go to 0 on the same edge.
- Regions, decoded from the counters:
  - active_h = h_cnt < H_ACTIVE.
  - hs_reg = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - active_v = v_cnt < V_ACTIVE.
  - vs_reg = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. Vsync changes only on h_cnt wrap boundaries.
- Outputs: all registered, with 1-cycle latency from the counters.
  - de = active_h & active_v.
  - hsync = hs_reg ? HS_POL : ~HS_POL. vsync is formed the same way from vs_reg and VS_POL.
  - x = h_cnt and y = v_cnt whenever de=1. When de=0, x and y hold 0.
  - line_start = (h_cnt==0) & active_v.
  - frame_start = (h_cnt==0) & (v_cnt==0).
  - vblank = ~active_v.
- State machine, two states:
  - IDLE: counters held at 0. hsync=~HS_POL, vsync=~VS_POL, de=0, pulses 0, vblank=1.
  - IDLE -> RUN on enable=1. The counters start from (0,0) that cycle. The next cycle shows de=1, frame_start=1, line_start=1, x=0, y=0.
  - RUN -> IDLE on enable=0 at any point mid-frame. On the following edge, counters clear and outputs take their idle values. No partial-line completion.
  - Re-enable always starts a fresh frame at (0,0).
- Reset: asynchronous assertion (reset=0) immediately forces IDLE, counters 0, and outputs to the idle values above. Deassertion is synchronised by the caller; the block does not resynchronise it.
- Simultaneous events: enable falling on the frame-wrap cycle -> IDLE wins. No extra frame_start is emitted.
- Counter arithmetic is unsigned CNT_W-bit. There is no overflow beyond the wrap compares.

Test Plan:
- Reset: hold reset=0 with enable=1 -> hsync=0, vsync=0, de=0, x=y=0, vblank=1. Release reset -> frame_start high exactly 2 cycles after the first clkin edge with reset=1.
- Line timing (defaults): measure from de rise.
  - de high for 800 cycles, then low for 256.
  - hsync rises 840 cycles after de rise and stays high 128 cycles.
  - line_start period is 1056 cycles.
- Frame timing (defaults):
  - 600 lines contain de.
  - vsync high for 4 lines beginning at the start of line 601, i.e. 601*1056 cycles after frame_start.
  - frame_start period is 663168 cycles. x reaches 799 and y reaches 599.
- Enable drop mid-frame (line 300, pixel 400) -> next cycle all outputs idle. Re-enable 10 cycles later -> frame_start=1, x=0, y=0 one cycle after enable rises.
- Small config (H 8/2/3/1, V 4/1/2/1, HS_POL=0, VS_POL=0):
  - hsync low for 3 cycles per 14-cycle line; vsync low for 2 lines per 8-line frame.
  - de asserted 32 cycles per frame.
  - Coordinates sweep (0..7, 0..3) in raster order.
- Asynchronous reset asserted mid-line, between edges -> outputs go idle without waiting for a clock edge. Counters restart at (0,0) after release.
